ram_dp_init: RTL and testbench
==============================

RAM_DP_INIT -- requirements
Module: ram_dp_init

Parameters
REQ-001 SHALL provide parameter DATA_WIDTH, default 64: data width in bits; multiple of 8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 12: address width in bits.
REQ-003 SHALL provide parameter DEPTH, default 4096: number of words, 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL provide parameter RD_LATENCY, default 1: cycles from read sample to rd_valid; legal values 1 or 2.
REQ-005 SHALL provide parameter RDW_MODE, default 0: same-address read-during-write policy; 0 = old data, 1 = new data.

Interface
REQ-006 clock  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 write  input  1  write request.
REQ-009 wr_address  input  ADDR_WIDTH  write word address.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 wr_be  input  DATA_WIDTH/8  byte enables; bit i covers data_in[8i+7:8i].
REQ-012 read  input  1  read request.
REQ-013 rd_address  input  ADDR_WIDTH  read word address.
REQ-014 data_out  output  DATA_WIDTH  read data.
REQ-015 rd_valid  output  1  data_out valid, one-cycle pulse per accepted read.
REQ-016 busy  output  1  initialisation in progress; requests ignored.
REQ-017 wr_err  output  1  one-cycle pulse: out-of-range write rejected.
REQ-018 rd_err  output  1  one-cycle pulse, aligned with rd_valid: out-of-range read.

Function
REQ-019 SHALL implement a two-state FSM, INIT and READY; reset forces INIT with init counter = 0.
REQ-020 In INIT, SHALL write all-zero to address = counter each cycle, increment counter, and enter READY on the cycle after writing address DEPTH-1 (DEPTH cycles in INIT).
REQ-021 busy SHALL be 1 while reset is high and in INIT, and 0 in READY.
REQ-022 In INIT, SHALL ignore write and read: no memory update from ports, no rd_valid, no wr_err, no rd_err.
REQ-023 In READY, write=1 with wr_address < DEPTH SHALL update only the bytes with wr_be[i]=1 at that rising edge; wr_be = 0 SHALL leave memory unchanged and raise no error.
REQ-024 In READY, write=1 with wr_address >= DEPTH SHALL leave memory unchanged and pulse wr_err for the following cycle.
REQ-025 In READY, read=1 sampled at edge N SHALL produce rd_valid=1 for exactly one cycle, beginning RD_LATENCY cycles after edge N; one read is accepted per cycle, fully pipelined.
REQ-026 Read with rd_address >= DEPTH SHALL return data_out = 0 with rd_valid=1 and rd_err=1 in the same cycle.
REQ-027 Same-cycle read and write to the same in-range address: RDW_MODE=0 SHALL return pre-write data; RDW_MODE=1 SHALL return stored data merged with the enabled data_in bytes.
REQ-028 Read and write to different addresses in the same cycle SHALL proceed independently.
REQ-029 data_out SHALL hold its last value while rd_valid=0.
REQ-030 RD_LATENCY=2 SHALL add one output register stage; RDW_MODE resolution SHALL happen at the sampling edge, independent of latency.

Reset
REQ-031 While reset is high, at each edge: data_out=0, rd_valid=0, wr_err=0, rd_err=0, busy=1, FSM=INIT, counter=0, read pipeline flushed.
REQ-032 Reset asserted mid-INIT or mid-read SHALL discard in-flight reads (no rd_valid pulse after reset) and restart INIT from address 0 after deassertion.
REQ-033 Memory contents SHALL NOT be relied on across reset; INIT re-zeroes all DEPTH words.

Verification (DATA_WIDTH=64, ADDR_WIDTH=12, DEPTH=16 unless stated)
REQ-034 Reset 2 cycles, then idle -> busy=1 for 16 cycles after deassertion, then 0; reads of addresses 0..15 return 0.
REQ-035 Write 0x1122334455667788 to address 3 with wr_be=0x0F, then read address 3 (RD_LATENCY=1) -> data_out=0x0000000055667788, rd_valid one cycle after the read.
REQ-036 Write to address 20 and read from address 17 in the same cycle -> wr_err pulse, rd_valid=rd_err=1, data_out=0, memory unchanged.
REQ-037 Address 5 holds 0xA; same-cycle write 0xB (wr_be=0xFF) and read of address 5 -> 0xA for RDW_MODE=0, 0xB for RDW_MODE=1.
REQ-038 RD_LATENCY=2, back-to-back reads of addresses 0..3 -> four consecutive rd_valid pulses starting 2 cycles after the first read, data in order.
REQ-039 Reset asserted mid-INIT (counter=7) and while 2 reads are in flight -> no rd_valid pulse after reset, busy=1, INIT restarts at address 0 and lasts 16 cycles.

Source files
------------

// File: rtl/ram_dp_init.sv
// Simple dual-port RAM with byte enables, self-zeroing after reset and a
// 1- or 2-stage read pipeline with configurable read-during-write behaviour.
module ram_dp_init #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    read,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    wr_err,
  output logic                    rd_err,
  output logic                    fsm_state
);

  // Handshake: requests are single-cycle strobes with no back-pressure. A
  // read or write is accepted exactly when it is high at a rising edge while
  // busy is low; requests seen while busy are dropped without any response.

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit NEW_DATA = (RDW_MODE == 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_INIT: begin
        if (count_q == LAST_ADDR) begin
          state_d = ST_READY;
          count_d = '0;
        end else begin
          count_d = count_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
      end
      default: state_d = ST_INIT;
    endcase
  end

  logic accept;
  logic wr_in_range, rd_in_range;
  logic rd_fire;

  assign fsm_state   = state_q;
  assign busy        = reset | (state_q == ST_INIT);
  assign accept      = ~reset & (state_q == ST_READY);
  assign wr_in_range = {1'b0, wr_address} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_address} < DEPTH_EXT;
  assign rd_fire     = accept & read;

  // The single write port is shared between the zeroing sweep and user writes.
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [NB-1:0]         mem_be;

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = count_q[IW-1:0];
    mem_din = '0;
    mem_be  = '1;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_we = 1'b1;
      end else if (write && wr_in_range) begin
        mem_we  = 1'b1;
        mem_idx = wr_address[IW-1:0];
        mem_din = data_in;
        mem_be  = wr_be;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_din[8*i +: 8];
      end
    end
  end

  logic [IW-1:0]         rd_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_idx = rd_in_range ? rd_address[IW-1:0] : '0;
  assign rd_hit = NEW_DATA & accept & write & wr_in_range & (wr_address == rd_address);

  // New-data mode forwards the enabled write bytes over the stored word.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < NB; i++) begin
      if (rd_hit && wr_be[i]) rd_word[8*i +: 8] = data_in[8*i +: 8];
    end
    if (!rd_in_range) rd_word = '0;
  end

  logic                  s1_valid, s1_err;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  wr_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      s1_err   <= rd_fire & ~rd_in_range;
      if (rd_fire) s1_data <= rd_word;
      wr_err_q <= accept & write & ~wr_in_range;
    end
  end

  assign wr_err = wr_err_q;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid, s2_err;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clock) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_err   = s2_err;
      assign data_out = s2_data;
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_err   = s1_err;
      assign data_out = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: one old-data/latency-1 and one new-data/latency-2
// instance share stimulus and are checked against a cycle-level memory model.
module tb_ram_dp_init;

  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 16;

  logic          clock, reset, write, read;
  logic [AW-1:0] wr_address, rd_address;
  logic [DW-1:0] data_in;
  logic [7:0]    wr_be;

  logic [DW-1:0] data_out_a, data_out_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b;
  logic          wr_err_a, wr_err_b, rd_err_a, rd_err_b;
  logic          state_a, state_b;

  ram_dp_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .write(write), .wr_address(wr_address), .data_in(data_in),
    .wr_be(wr_be), .read(read), .rd_address(rd_address), .data_out(data_out_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .wr_err(wr_err_a), .rd_err(rd_err_a), .fsm_state(state_a)
  );

  ram_dp_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .write(write), .wr_address(wr_address), .data_in(data_in),
    .wr_be(wr_be), .read(read), .rd_address(rd_address), .data_out(data_out_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .wr_err(wr_err_b), .rd_err(rd_err_b), .fsm_state(state_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rd_t;

  rd_t           exp_qa[$];
  rd_t           exp_qb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            init_left = DEPTH;
  int            edge_n = 0;
  logic          exp_wr_err = 1'b0;
  logic [DW-1:0] held_a = '0;
  logic [DW-1:0] held_b = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [7:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // Effect of one rising edge on the reference, using the inputs driven for it.
  task automatic model_edge();
    logic          in_rng;
    logic [DW-1:0] old_w, new_w;
    edge_n++;
    exp_wr_err = 1'b0;
    if (reset) begin
      init_left = DEPTH;
      exp_qa.delete();
      exp_qb.delete();
      held_a = '0;
      held_b = '0;
    end else if (init_left > 0) begin
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      if (read) begin
        in_rng = rd_address < AW'(DEPTH);
        old_w  = in_rng ? ref_mem[rd_address[3:0]] : '0;
        new_w  = old_w;
        if (in_rng && write && wr_address == rd_address) new_w = merge(old_w, data_in, wr_be);
        exp_qa.push_back('{edge_n, old_w, !in_rng});
        exp_qb.push_back('{edge_n + 1, new_w, !in_rng});
      end
      if (write) begin
        if (wr_address < AW'(DEPTH)) ref_mem[wr_address[3:0]] = merge(ref_mem[wr_address[3:0]], data_in, wr_be);
        else exp_wr_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic          ev, ee, exp_busy;
    logic [DW-1:0] ed;
    exp_busy = reset || (init_left > 0);
    ev = 1'b0; ee = 1'b0; ed = held_a;
    if (exp_qa.size() > 0 && exp_qa[0].due == edge_n) begin
      ev = 1'b1; ee = exp_qa[0].err; ed = exp_qa[0].data; held_a = ed;
      void'(exp_qa.pop_front());
    end
    chk("a.rd_valid", DW'(rd_valid_a), DW'(ev));
    chk("a.rd_err", DW'(rd_err_a), DW'(ee));
    chk("a.data_out", data_out_a, ed);
    chk("a.busy", DW'(busy_a), DW'(exp_busy));
    chk("a.wr_err", DW'(wr_err_a), DW'(exp_wr_err));
    chk("a.state", DW'(state_a), DW'(init_left == 0));
    ev = 1'b0; ee = 1'b0; ed = held_b;
    if (exp_qb.size() > 0 && exp_qb[0].due == edge_n) begin
      ev = 1'b1; ee = exp_qb[0].err; ed = exp_qb[0].data; held_b = ed;
      void'(exp_qb.pop_front());
    end
    chk("b.rd_valid", DW'(rd_valid_b), DW'(ev));
    chk("b.rd_err", DW'(rd_err_b), DW'(ee));
    chk("b.data_out", data_out_b, ed);
    chk("b.busy", DW'(busy_b), DW'(exp_busy));
    chk("b.wr_err", DW'(wr_err_b), DW'(exp_wr_err));
  endtask

  task automatic cycle(input logic rst, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] di, input logic [7:0] be,
                       input logic r, input logic [AW-1:0] ra);
    reset = rst; write = w; wr_address = wa; data_in = di; wr_be = be;
    read = r; rd_address = ra;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0;
    wr_address = '0; rd_address = '0; data_in = '0; wr_be = '0;

    // Reset for two cycles, then zeroing sweep with requests that must be ignored.
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    cycle(1'b1, 1'b1, 12'd1, 64'hdead, 8'hff, 1'b1, 12'd1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, i[0], 12'd2, {$urandom, $urandom}, 8'hff, ~i[0], AW'(i));

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
    idle(2);

    // Partial byte-enable write, then read back.
    cycle(1'b0, 1'b1, 12'd3, 64'h1122334455667788, 8'h0f, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 12'd3);
    idle(2);

    // Out-of-range write and read together, then confirm memory untouched.
    cycle(1'b0, 1'b1, 12'd20, 64'hffff_ffff_ffff_ffff, 8'hff, 1'b1, 12'd17);
    cycle(1'b0, 1'b1, 12'd4095, 64'h1, 8'hff, 1'b1, 12'd4095);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 12'd4);
    idle(2);

    // Read-during-write on the same address, full and partial enables.
    cycle(1'b0, 1'b1, 12'd5, 64'ha, 8'hff, 1'b0, '0);
    cycle(1'b0, 1'b1, 12'd5, 64'hb, 8'hff, 1'b1, 12'd5);
    cycle(1'b0, 1'b1, 12'd5, 64'hcccc_cccc_cccc_cccc, 8'h81, 1'b1, 12'd5);
    cycle(1'b0, 1'b1, 12'd6, 64'h77, 8'h00, 1'b1, 12'd6);
    cycle(1'b0, 1'b1, 12'd7, 64'h99, 8'hff, 1'b1, 12'd5);
    idle(3);

    // Back-to-back reads, fully pipelined.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
    idle(3);

    // Randomized traffic across in-range and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      logic [7:0]    be;
      wa = AW'($urandom_range(0, 23));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 23));
      be = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle(1'b0, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, be,
            1'($urandom_range(0, 1)), ra);
    end
    idle(3);

    // Reset with reads in flight, then reset again partway through the sweep.
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 12'd2);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 12'd3);
    cycle(1'b1, 1'b1, 12'd1, 64'h5, 8'hff, 1'b1, 12'd1);
    idle(7);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b1, AW'(i), {$urandom, $urandom}, 8'hff, 1'b1, AW'(i));

    // Every word must read back zero after the second sweep.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
    idle(4);

    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain: reads still pending a=%0d b=%0d expected 0", exp_qa.size(), exp_qb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
